// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Number of address bits needed to index 'depth' entries.
  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one write port, one registered read port.
// The array itself carries no reset so it can map onto block or distributed RAM.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; no reset so the array stays RAM-inferable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds the last word when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow and synchronous flush.
// Full/empty come from the occupancy count; pointers simply wrap.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = clog2_depth(DEPTH) + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  // Flags as they must read with count == 0.
  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  (AF_LEVEL == 0),
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  fifo_status_t      status_q;
  fifo_status_t      status_nxt;
  logic              rd_valid_q;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance, next count and next flags, all from the pre-edge state.
  // A write into a full FIFO is allowed when a read frees a slot the same
  // cycle; a read from an empty FIFO is never bypassed from the write.
  always_comb begin
    wr_ok  = w_en & (~status_q.full | r_en);
    rd_ok  = r_en & ~status_q.empty;
    wr_acc = wr_ok & ~clr;
    rd_acc = rd_ok & ~clr;

    count_nxt = count_q;
    if (clr) count_nxt = '0;
    else if (wr_ok && !rd_ok) count_nxt = count_q + CNT_W'(1);
    else if (rd_ok && !wr_ok) count_nxt = count_q - CNT_W'(1);

    status_nxt              = STATUS_RST;
    status_nxt.full         = (count_nxt == FULL_CNT);
    status_nxt.empty        = (count_nxt == '0);
    status_nxt.almost_full  = (count_nxt >= AF_CNT);
    status_nxt.almost_empty = (count_nxt <= AE_CNT);
    status_nxt.overflow     = ~clr & (status_q.overflow  | (w_en & ~wr_ok));
    status_nxt.underflow    = ~clr & (status_q.underflow | (r_en & ~rd_ok));
  end

  // Pointer, count, flag and read-strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      status_q   <= STATUS_RST;
      rd_valid_q <= 1'b0;
    end else begin
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      count_q    <= count_nxt;
      status_q   <= status_nxt;
      rd_valid_q <= rd_acc;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (DATA_W=8, ADDR_W=2, AF=3, AE=1).
module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo_ctrl #(
    .DATA_W   (8),
    .ADDR_W   (2),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic       c;
    logic [7:0] din;
    logic [2:0] cnt;
    logic [7:0] dout;
    logic       rv;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];

  // Observed outputs packed as {count, data_out, rd_valid, full, empty, af, ae, ov, un}.
  function automatic logic [17:0] observed();
    return {count, data_out, rd_valid, full, empty, almost_full, almost_empty,
            overflow, underflow};
  endfunction

  // Expected outputs; flags follow from the count by their definitions.
  function automatic logic [17:0] expected(input logic [2:0] cnt, input logic [7:0] dout,
                                           input logic rv, input logic ov, input logic un);
    return {cnt, dout, rv, (cnt == 3'd4), (cnt == 3'd0), (cnt >= 3'd3), (cnt <= 3'd1), ov, un};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d dout=%h rv=%b fu/em/af/ae/ov/un=%b, want cnt=%0d dout=%h rv=%b fu/em/af/ae/ov/un=%b",
               name, act[17:15], act[14:7], act[6], act[5:0], exp[17:15], exp[14:7], exp[6], exp[5:0]);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic c, input logic [7:0] din,
                     input logic [2:0] cnt, input logic [7:0] dout, input logic rv,
                     input logic ov, input logic un);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.din = din;
    v.cnt = cnt; v.dout = dout; v.rv = rv; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] din);
    @(negedge clk);
    w_en = w; r_en = r; clr = c; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;

    //  w  r  c  din    cnt   dout   rv ov un
    // fill, then reject a fifth write
    add(1, 0, 0, 8'hA1, 3'd1, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'hB2, 3'd2, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'hC3, 3'd3, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'hD4, 3'd4, 8'h00, 0, 0, 0);
    add(1, 0, 0, 8'hE5, 3'd4, 8'h00, 0, 1, 0);
    // drain, then reject a fifth read
    add(0, 1, 0, 8'h00, 3'd3, 8'hA1, 1, 1, 0);
    add(0, 1, 0, 8'h00, 3'd2, 8'hB2, 1, 1, 0);
    add(0, 1, 0, 8'h00, 3'd1, 8'hC3, 1, 1, 0);
    add(0, 1, 0, 8'h00, 3'd0, 8'hD4, 1, 1, 0);
    add(0, 1, 0, 8'h00, 3'd0, 8'hD4, 0, 1, 1);
    // flush clears stickies, keeps data_out
    add(0, 0, 1, 8'h00, 3'd0, 8'hD4, 0, 0, 0);
    // full, simultaneous write+read, then drain across the wrap
    add(1, 0, 0, 8'hA1, 3'd1, 8'hD4, 0, 0, 0);
    add(1, 0, 0, 8'hB2, 3'd2, 8'hD4, 0, 0, 0);
    add(1, 0, 0, 8'hC3, 3'd3, 8'hD4, 0, 0, 0);
    add(1, 0, 0, 8'hD4, 3'd4, 8'hD4, 0, 0, 0);
    add(1, 1, 0, 8'h55, 3'd4, 8'hA1, 1, 0, 0);
    add(0, 1, 0, 8'h00, 3'd3, 8'hB2, 1, 0, 0);
    add(0, 1, 0, 8'h00, 3'd2, 8'hC3, 1, 0, 0);
    add(0, 1, 0, 8'h00, 3'd1, 8'hD4, 1, 0, 0);
    add(0, 1, 0, 8'h00, 3'd0, 8'h55, 1, 0, 0);
    // empty, simultaneous write+read: write accepted, read rejected
    add(1, 1, 0, 8'h77, 3'd1, 8'h55, 0, 0, 1);
    add(0, 1, 0, 8'h00, 3'd0, 8'h77, 1, 0, 1);
    // build count=3 with overflow set
    add(1, 0, 0, 8'h11, 3'd1, 8'h77, 0, 0, 1);
    add(1, 0, 0, 8'h22, 3'd2, 8'h77, 0, 0, 1);
    add(1, 0, 0, 8'h33, 3'd3, 8'h77, 0, 0, 1);
    add(1, 0, 0, 8'h44, 3'd4, 8'h77, 0, 0, 1);
    add(1, 0, 0, 8'h99, 3'd4, 8'h77, 0, 1, 1);
    add(0, 1, 0, 8'h00, 3'd3, 8'h11, 1, 1, 1);
    // clr beats w_en; the write must not land
    add(1, 0, 1, 8'h66, 3'd0, 8'h11, 0, 0, 0);
    add(0, 1, 0, 8'h00, 3'd0, 8'h11, 0, 0, 1);
    add(0, 0, 0, 8'h00, 3'd0, 8'h11, 0, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", observed(), expected(3'd0, 8'h00, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].din);
      check($sformatf("vec%0d", i), observed(),
            expected(vecs[i].cnt, vecs[i].dout, vecs[i].rv, vecs[i].ov, vecs[i].un));
    end

    // Asynchronous reset mid-burst at count=2.
    step(1, 0, 0, 8'h5A);
    step(1, 0, 0, 8'h6B);
    check("pre_rst_count2", observed(), expected(3'd2, 8'h11, 0, 0, 1));
    @(negedge clk);
    w_en = 1'b1; data_in = 8'h7C;
    #2 rst = 1'b1;
    #1;
    check("async_rst_now", observed(), expected(3'd0, 8'h00, 0, 0, 0));
    @(posedge clk);
    #1;
    check("rst_held_edge", observed(), expected(3'd0, 8'h00, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0; w_en = 1'b0;
    step(1, 0, 0, 8'hA5);
    check("post_rst_write", observed(), expected(3'd1, 8'h00, 0, 0, 0));
    step(0, 1, 0, 8'h00);
    check("post_rst_read", observed(), expected(3'd0, 8'hA5, 1, 0, 0));
    step(0, 0, 0, 8'h00);
    check("post_rst_idle", observed(), expected(3'd0, 8'hA5, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
